sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx.sv | 125 ++++++++++++
 tb/tb_sipo_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver with a one-word output holding register and overrun/parity flags.
// Optional feature: define SIPO_PARITY_EN to receive an extra even-parity bit per word.
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SIPO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CNT_W = $clog2(NBITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             pout_valid_q, pout_valid_d;
    logic             overrun_q, overrun_d;
`ifdef SIPO_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST)
            return {cur[WIDTH-2:0], b};
        else
            return {b, cur[WIDTH-1:1]};
    endfunction

    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        pout_d       = pout_q;
        pout_valid_d = pout_valid_q;
        overrun_d    = overrun_q;
`ifdef SIPO_PARITY_EN
        par_d        = par_q;
        perr_d       = perr_q;
`endif
        if (pout_valid_q && pout_ready)
            pout_valid_d = 1'b0;

        if (clr) begin
            // Abort drops any bit offered on this edge; the output word is left alone.
            cnt_d     = '0;
            shift_d   = '0;
            overrun_d = 1'b0;
`ifdef SIPO_PARITY_EN
            par_d     = 1'b0;
`endif
        end else if (sin_valid) begin
            if (cnt_q == LAST) begin
                cnt_d        = '0;
                shift_d      = '0;
                pout_valid_d = 1'b1;
                if (pout_valid_q && !pout_ready)
                    overrun_d = 1'b1;
`ifdef SIPO_PARITY_EN
                // Final bit is the parity bit; data is already fully assembled.
                pout_d = shift_q;
                perr_d = par_q ^ sin;
                par_d  = 1'b0;
`else
                pout_d = shift_in(shift_q, sin);
`endif
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                shift_d = shift_in(shift_q, sin);
`ifdef SIPO_PARITY_EN
                par_d   = par_q ^ sin;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            pout_q       <= pout_d;
            pout_valid_q <= pout_valid_d;
            overrun_q    <= overrun_d;
`ifdef SIPO_PARITY_EN
            par_q        <= par_d;
            perr_q       <= perr_d;
`endif
        end
    end

    assign pout       = pout_q;
    assign pout_valid = pout_valid_q;
    assign busy       = (cnt_q != '0);
    assign overrun    = overrun_q;
`ifdef SIPO_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: MSB-first and LSB-first instances driven in parallel, checked against
// hand-written vectors and a queue-based reference model under random stimulus.
module tb_sipo_rx;
    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic rst, sin, sin_valid, clr, pout_ready;
    logic [W-1:0] pout_m, pout_l;
    logic pv_m, pv_l, busy_m, busy_l, ov_m, ov_l, pe_m, pe_l;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .pout(pout_m), .pout_valid(pv_m), .pout_ready(pout_ready),
        .busy(busy_m), .overrun(ov_m), .parity_err(pe_m));

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .pout(pout_l), .pout_valid(pv_l), .pout_ready(pout_ready),
        .busy(busy_l), .overrun(ov_l), .parity_err(pe_l));

    int checks = 0;
    int failures = 0;

    // Reference model: received bits kept as a plain queue.
    bit       mbits[$];
    bit [W-1:0] m_pm, m_pl;
    bit       m_v, m_ov, m_pe;

    typedef struct {
        bit rst, sin, sv, clr, rdy;
        bit [W-1:0] pm, pl;
        bit v, b, ov, pe;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit v, input bit c, input bit y);
        bit x;
        if (r) begin
            mbits.delete();
            m_pm = '0; m_pl = '0; m_v = 0; m_ov = 0; m_pe = 0;
        end else begin
            bit old_v;
            old_v = m_v;
            if (m_v && y) m_v = 0;
            if (c) begin
                mbits.delete();
                m_ov = 0;
            end else if (v) begin
                mbits.push_back(s);
                if (mbits.size() == NB) begin
                    x = 0;
                    for (int i = 0; i < NB; i++) x = x ^ mbits[i];
                    for (int i = 0; i < W; i++) begin
                        m_pm[W-1-i] = mbits[i];
                        m_pl[i]     = mbits[i];
                    end
`ifdef SIPO_PARITY_EN
                    m_pe = x;
`else
                    m_pe = 0;
`endif
                    if (old_v && !y) m_ov = 1;
                    m_v = 1;
                    mbits.delete();
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit v, input bit c, input bit y);
        rst = r; sin = s; sin_valid = v; clr = c; pout_ready = y;
        @(posedge clk);
        model_edge(r, s, v, c, y);
        #1;
        chk("pout_msb", int'(pout_m), int'(m_pm));
        chk("pout_lsb", int'(pout_l), int'(m_pl));
        chk("pout_valid", int'(pv_m), int'(m_v));
        chk("pout_valid_lsb", int'(pv_l), int'(m_v));
        chk("busy", int'(busy_m), int'(mbits.size() != 0));
        chk("busy_lsb", int'(busy_l), int'(mbits.size() != 0));
        chk("overrun", int'(ov_m), int'(m_ov));
        chk("overrun_lsb", int'(ov_l), int'(m_ov));
        chk("parity_err", int'(pe_m), int'(m_pe));
        chk("parity_err_lsb", int'(pe_l), int'(m_pe));
    endtask

    function automatic vec_t row(bit r, bit s, bit v, bit c, bit y,
                                 bit [W-1:0] pm, bit [W-1:0] pl, bit ev, bit eb, bit eo, bit ep);
        vec_t t;
        t.rst = r; t.sin = s; t.sv = v; t.clr = c; t.rdy = y;
        t.pm = pm; t.pl = pl; t.v = ev; t.b = eb; t.ov = eo; t.pe = ep;
        return t;
    endfunction

    initial begin
        bit data[4];
        rst = 1; sin = 0; sin_valid = 0; clr = 0; pout_ready = 0;

`ifdef SIPO_PARITY_EN
        vecs.push_back(row(1,0,0,0,0, 4'h0,4'h0, 0,0,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h0,4'h0, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'h0,4'h0, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h0,4'h0, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h0,4'h0, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'hB,4'hD, 1,0,0,0));
        vecs.push_back(row(0,0,0,0,1, 4'hB,4'hD, 0,0,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'hB,4'hD, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'hB,4'hD, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'hB,4'hD, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'hB,4'hD, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'hB,4'hD, 1,0,0,1));
        vecs.push_back(row(0,0,0,0,0, 4'hB,4'hD, 1,0,0,1));
        vecs.push_back(row(0,0,0,0,1, 4'hB,4'hD, 0,0,0,1));
`else
        vecs.push_back(row(1,0,0,0,0, 4'h0,4'h0, 0,0,0,0));
        // 1,0,1,1 then hold, then consume
        vecs.push_back(row(0,1,1,0,0, 4'h0,4'h0, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'h0,4'h0, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h0,4'h0, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'hB,4'hD, 1,0,0,0));
        vecs.push_back(row(0,0,0,0,0, 4'hB,4'hD, 1,0,0,0));
        vecs.push_back(row(0,0,0,0,1, 4'hB,4'hD, 0,0,0,0));
        // A then 5, never consumed -> overrun
        vecs.push_back(row(0,1,1,0,0, 4'hB,4'hD, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'hB,4'hD, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'hB,4'hD, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'hA,4'h5, 1,0,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'hA,4'h5, 1,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'hA,4'h5, 1,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'hA,4'h5, 1,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h5,4'hA, 1,0,1,0));
        vecs.push_back(row(0,0,0,1,1, 4'h5,4'hA, 0,0,0,0));
        // A then 5, second completion coincides with consume
        vecs.push_back(row(0,1,1,0,0, 4'h5,4'hA, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'h5,4'hA, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h5,4'hA, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'hA,4'h5, 1,0,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'hA,4'h5, 1,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'hA,4'h5, 1,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'hA,4'h5, 1,1,0,0));
        vecs.push_back(row(0,1,1,0,1, 4'h5,4'hA, 1,0,0,0));
        vecs.push_back(row(0,0,0,0,1, 4'h5,4'hA, 0,0,0,0));
        // clr after 2 bits (bit on the clr edge is dropped), then 0,1,1,0
        vecs.push_back(row(0,1,1,0,0, 4'h5,4'hA, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h5,4'hA, 0,1,0,0));
        vecs.push_back(row(0,1,1,1,0, 4'h5,4'hA, 0,0,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'h5,4'hA, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h5,4'hA, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h5,4'hA, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'h6,4'h6, 1,0,0,0));
        // rst after 3 bits, then a full fresh word 1,1,0,0
        vecs.push_back(row(0,1,1,0,1, 4'h6,4'h6, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'h6,4'h6, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h6,4'h6, 0,1,0,0));
        vecs.push_back(row(1,1,1,0,0, 4'h0,4'h0, 0,0,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h0,4'h0, 0,1,0,0));
        vecs.push_back(row(0,1,1,0,0, 4'h0,4'h0, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'h0,4'h0, 0,1,0,0));
        vecs.push_back(row(0,0,1,0,0, 4'hC,4'h3, 1,0,0,0));
        vecs.push_back(row(0,0,0,0,1, 4'hC,4'h3, 0,0,0,0));
`endif

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].sin, vecs[k].sv, vecs[k].clr, vecs[k].rdy);
            chk($sformatf("vec%0d_pout_msb", k), int'(pout_m), int'(vecs[k].pm));
            chk($sformatf("vec%0d_pout_lsb", k), int'(pout_l), int'(vecs[k].pl));
            chk($sformatf("vec%0d_valid", k), int'(pv_m), int'(vecs[k].v));
            chk($sformatf("vec%0d_busy", k), int'(busy_m), int'(vecs[k].b));
            chk($sformatf("vec%0d_overrun", k), int'(ov_m), int'(vecs[k].ov));
            chk($sformatf("vec%0d_parity_err", k), int'(pe_m), int'(vecs[k].pe));
        end

        // Bits 1,0,1,1 (plus parity 1 when enabled) with 3 idle cycles between each.
        step(1, 0, 0, 0, 0);
        data[0] = 1; data[1] = 0; data[2] = 1; data[3] = 1;
        for (int i = 0; i < NB; i++) begin
            step(0, (i < 4) ? data[i] : 1'b1, 1, 0, 0);
            for (int g = 0; g < 3; g++) begin
                step(0, 0, 0, 0, 0);
                chk($sformatf("gap_busy_b%0d", i), int'(busy_l), int'(i < NB - 1));
            end
        end
        chk("gap_pout_lsb", int'(pout_l), 13);
        chk("gap_pout_msb", int'(pout_m), 11);
        chk("gap_valid", int'(pv_l), 1);
        chk("gap_parity_err", int'(pe_l), 0);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            step(($urandom_range(63) == 0), 1'($urandom), ($urandom_range(1) == 1),
                 ($urandom_range(15) == 0), ($urandom_range(2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
